// File: rtl/tetris_input_pkg.sv
// Shared command codes, FSM encoding and pending-bit indices for tetris_input_sched.
package tetris_input_pkg;

  localparam logic [2:0] CMD_NONE      = 3'd0;
  localparam logic [2:0] CMD_LEFT      = 3'd1;
  localparam logic [2:0] CMD_RIGHT     = 3'd2;
  localparam logic [2:0] CMD_ROTATE    = 3'd3;
  localparam logic [2:0] CMD_SOFT_DOWN = 3'd4;
  localparam logic [2:0] CMD_HARD_DROP = 3'd5;
  localparam logic [2:0] CMD_GRAVITY   = 3'd6;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  localparam int unsigned P_LEFT  = 0;
  localparam int unsigned P_RIGHT = 1;
  localparam int unsigned P_ROT   = 2;
  localparam int unsigned P_DOWN  = 3;
  localparam int unsigned P_DROP  = 4;
  localparam int unsigned P_GRAV  = 5;

  // Fixed priority: HARD_DROP > GRAVITY > ROTATE > LEFT > RIGHT > SOFT_DOWN.
  function automatic logic [2:0] f_pick(input logic [5:0] pend);
    logic [2:0] code;
    code = CMD_NONE;
    if (pend[P_DROP])       code = CMD_HARD_DROP;
    else if (pend[P_GRAV])  code = CMD_GRAVITY;
    else if (pend[P_ROT])   code = CMD_ROTATE;
    else if (pend[P_LEFT])  code = CMD_LEFT;
    else if (pend[P_RIGHT]) code = CMD_RIGHT;
    else if (pend[P_DOWN])  code = CMD_SOFT_DOWN;
    return code;
  endfunction

  // A hard drop makes any queued gravity step or soft drop meaningless.
  function automatic logic [5:0] f_clr_mask(input logic [2:0] code);
    logic [5:0] mask;
    mask = 6'b0;
    case (code)
      CMD_LEFT:      mask[P_LEFT]  = 1'b1;
      CMD_RIGHT:     mask[P_RIGHT] = 1'b1;
      CMD_ROTATE:    mask[P_ROT]   = 1'b1;
      CMD_SOFT_DOWN: mask[P_DOWN]  = 1'b1;
      CMD_HARD_DROP: begin
        mask[P_DROP] = 1'b1;
        mask[P_GRAV] = 1'b1;
        mask[P_DOWN] = 1'b1;
      end
      CMD_GRAVITY:   mask[P_GRAV]  = 1'b1;
      default:       mask = 6'b0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/btn_edge_repeat.sv
// Rising-edge detector with optional DAS/ARR auto-repeat; emits a 1-cycle set pulse.
// Repeat counter exists only when TETRIS_AUTO_REPEAT_EN is defined and REPEAT_EN=1.
module btn_edge_repeat #(
  parameter int unsigned     CNT_W      = 25,
  parameter logic [CNT_W-1:0] DAS_DELAY  = 25'd2000000,
  parameter logic [CNT_W-1:0] ARR_PERIOD = 25'd500000,
  parameter bit              REPEAT_EN  = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  input  logic i_game_over,
  output logic o_set
);

  logic r_prev;
  logic w_rep;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_prev <= 1'b0;
    else         r_prev <= i_btn;
  end

`ifdef TETRIS_AUTO_REPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam logic [CNT_W-1:0] ONE    = 1;
    localparam logic [CNT_W-1:0] RELOAD = DAS_DELAY - ARR_PERIOD;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    // Saturating increment; the reload normally keeps it well below the top.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + ONE;
    assign w_rep     = i_btn && !i_game_over && (w_cnt_inc == DAS_DELAY);

    always_ff @(posedge i_clk) begin
      if (i_reset || !i_btn || i_game_over) r_cnt <= '0;
      else if (w_rep)                       r_cnt <= RELOAD;
      else                                  r_cnt <= w_cnt_inc;
    end
  end else begin : g_norep
    assign w_rep = 1'b0;
  end
`else
  assign w_rep = 1'b0;
`endif

  assign o_set = ((i_btn && !r_prev) || w_rep) && !i_game_over;

endmodule

// File: rtl/tetris_input_sched.sv
// Latches button/gravity requests and issues one command at a time over valid/ready.
// Optional auto-repeat for LEFT/RIGHT/DOWN via TETRIS_AUTO_REPEAT_EN.
module tetris_input_sched
  import tetris_input_pkg::*;
#(
  parameter int unsigned      CNT_W      = 25,
  parameter logic [CNT_W-1:0] DAS_DELAY  = 25'd2000000,
  parameter logic [CNT_W-1:0] ARR_PERIOD = 25'd500000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_rotate,
  input  logic       i_btn_down,
  input  logic       i_btn_drop,
  input  logic       i_grav_tick,
  input  logic       i_game_over,
  input  logic       i_cmd_ready,
  output logic       o_cmd_valid,
  output logic [2:0] o_cmd_code,
  output logic [5:0] o_pending
);

  logic       r_state;
  logic       r_cmd_valid;
  logic [2:0] r_cmd_code;
  logic [5:0] r_pending;

  logic [5:0] w_set;
  logic [5:0] w_clr;
  logic [5:0] w_pending_d;
  logic [2:0] w_winner;
  logic       w_grant;

  btn_edge_repeat #(
    .CNT_W(CNT_W), .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT_EN(1'b1)
  ) u_left (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_left), .i_game_over(i_game_over),
    .o_set(w_set[P_LEFT])
  );

  btn_edge_repeat #(
    .CNT_W(CNT_W), .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT_EN(1'b1)
  ) u_right (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_right), .i_game_over(i_game_over),
    .o_set(w_set[P_RIGHT])
  );

  btn_edge_repeat #(
    .CNT_W(CNT_W), .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT_EN(1'b0)
  ) u_rotate (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_rotate), .i_game_over(i_game_over),
    .o_set(w_set[P_ROT])
  );

  btn_edge_repeat #(
    .CNT_W(CNT_W), .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT_EN(1'b1)
  ) u_down (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_down), .i_game_over(i_game_over),
    .o_set(w_set[P_DOWN])
  );

  btn_edge_repeat #(
    .CNT_W(CNT_W), .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT_EN(1'b0)
  ) u_drop (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_drop), .i_game_over(i_game_over),
    .o_set(w_set[P_DROP])
  );

  assign w_set[P_GRAV] = i_grav_tick && !i_game_over;

  // New sets are OR-ed in after the clear so a same-cycle set survives a grant.
  always_comb begin
    w_winner    = f_pick(r_pending);
    w_grant     = (r_state == ST_ISSUE) && i_cmd_ready;
    w_clr       = w_grant ? f_clr_mask(r_cmd_code) : 6'b0;
    w_pending_d = (r_pending & ~w_clr) | w_set;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_game_over) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= CMD_NONE;
      r_pending   <= 6'b0;
    end else begin
      r_pending <= w_pending_d;
      case (r_state)
        ST_IDLE: begin
          if (|r_pending) begin
            r_state     <= ST_ISSUE;
            r_cmd_valid <= 1'b1;
            r_cmd_code  <= w_winner;
          end
        end
        ST_ISSUE: begin
          if (i_cmd_ready) begin
            r_state     <= ST_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= CMD_NONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_code  = r_cmd_code;
  assign o_pending   = r_pending;

endmodule

// File: doc/tetris_input_sched.md
Name: tetris_input_sched

Overview:
Collects debounced player buttons and the gravity tick, latches each as a pending request, and issues exactly one move command at a time to the game engine over a valid/ready handshake. Sits between the per-button debouncers and the piece-movement/collision engine. Arbitration is fixed-priority. Requests are never lost while the engine is busy.

Parameters:
CNT_W, 25, width of the auto-repeat counters
DAS_DELAY, 25'd2000000, cycles a held button must stay high before auto-repeat starts
ARR_PERIOD, 25'd500000, cycles between auto-repeat requests once repeating

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_left  in  1  debounced level, active-high
btn_right  in  1  debounced level, active-high
btn_rotate  in  1  debounced level, active-high
btn_down  in  1  debounced level, soft drop
btn_drop  in  1  debounced level, hard drop
grav_tick  in  1  one-cycle pulse from the fall-rate timer
game_over  in  1  level; while high, all requests are flushed and ignored
cmd_ready  in  1  engine accepts the current command
cmd_valid  out  1  command presented
cmd_code  out  3  1=LEFT 2=RIGHT 3=ROTATE 4=SOFT_DOWN 5=HARD_DROP 6=GRAVITY; 0 when idle
pending  out  6  live request bits {GRAV,DROP,DOWN,ROT,RIGHT,LEFT}, for debug

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. On reset, cmd_valid=0, cmd_code=0, pending=0, FSM=IDLE, all counters=0, edge registers=0.
- Edge detect: each button is registered once. A rising edge (prev=0, cur=1) sets that button's pending bit on the next clock. A grav_tick pulse sets GRAV.
- A set on a bit in the same cycle that the bit is cleared by a grant wins. Each bit holds at most one request; further edges while it is set are merged.
- FSM IDLE: if any pending bit is set and game_over=0, go to ISSUE on the next clock. Latch the winner into cmd_code and assert cmd_valid.
- Priority, highest first: HARD_DROP > GRAVITY > ROTATE > LEFT > RIGHT > SOFT_DOWN.
- FSM ISSUE: cmd_valid and cmd_code stay stable until cmd_ready=1.
  - On the handshake cycle, clear the granted bit, drop cmd_valid, set cmd_code=0, and return to IDLE.
  - Minimum spacing is therefore 2 cycles per command.
  - A HARD_DROP grant also clears GRAV and DOWN.
- Requests arriving during ISSUE only set pending bits. They never change the command in flight.
- game_over=1:
  - Pending is cleared every cycle.
  - From ISSUE, go to IDLE immediately with cmd_valid=0, with or without cmd_ready.
  - Edges seen while game_over is high are discarded.
- LEFT and RIGHT both pending: LEFT is served first, then RIGHT. Neither is cancelled.
- Reset mid-ISSUE: the command is abandoned and no handshake is expected.

Optional Feature:
Macro: TETRIS_AUTO_REPEAT_EN
- Defined: LEFT, RIGHT and DOWN each have a CNT_W-bit hold counter.
  - The counter counts while the button is high and clears when it is low or game_over=1.
  - When the counter reaches DAS_DELAY, set pending and reload the counter to DAS_DELAY-ARR_PERIOD. This gives further sets every ARR_PERIOD cycles.
  - The counter saturates and never wraps.
- Undefined: edge-only behaviour and no repeat counters. ROTATE, DROP and GRAV never repeat in either build.

Decomposition:
- Package tetris_input_pkg holds:
  - cmd_code localparams CMD_NONE through CMD_GRAVITY
  - FSM state encoding ST_IDLE=0, ST_ISSUE=1
  - pending bit index constants
- Sub-module btn_edge_repeat does edge detect plus the optional DAS/ARR counter and outputs a 1-cycle set pulse. Instantiate it 5 times, with repeat enabled only for LEFT, RIGHT and DOWN. Arbiter and FSM stay in the top.

Test Plan:
- Reset then idle 20 cycles -> cmd_valid=0, cmd_code=0, pending=0.
- btn_rotate rising edge, cmd_ready tied 1 -> pending[ROT] set at cycle+1, cmd_valid=1 with code 3 at cycle+2, cleared at cycle+3.
- btn_left and btn_drop rise together, cmd_ready=1 -> code 5 issued first, then code 1. GRAV set beforehand is cleared by the drop grant.
- cmd_ready held 0 for 10 cycles while ROTATE issued and btn_right rises -> code 3 stable all 10 cycles. Code 2 follows two cycles after the handshake.
- game_over asserted during ISSUE -> cmd_valid=0 next cycle, pending=0, and new edges are ignored until game_over drops.
- With TETRIS_AUTO_REPEAT_EN, DAS_DELAY=8, ARR_PERIOD=3, btn_left held 20 cycles -> LEFT is set on the edge, then at hold counts 8, 11, 14, 17. Without the macro, LEFT is set once only.
